// File: rtl/ioctl_upload_io.sv
// ioctl_upload_io: SPI-side uploader streaming core memory bytes out on SPI_DO; `define UPLOAD_CHECKSUM_EN adds a running checksum read by command 8'h59
module ioctl_upload_io #(
   parameter int         RD_LATENCY  = 2,
   parameter logic [7:0] CMD_INDEX   = 8'h55,
   parameter logic [7:0] CMD_RX_CTRL = 8'h57,
   parameter logic [7:0] CMD_RX_DAT  = 8'h58
) (
   input  logic        clock_12,
   input  logic        reset,
   input  logic        SPI_SCK,
   input  logic        SPI_SS2,
   input  logic        SPI_DI,
   output logic        SPI_DO,
   output logic        SPI_DO_EN,
   output logic        ioctl_upload,
   output logic [7:0]  ioctl_index,
   output logic        ioctl_rd,
   output logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_din
);
   typedef enum logic [2:0] {IDLE, CMD, ARG_INDEX, ARG_CTRL, DATA} state_t;
   state_t state_q, state_d;
   logic [2:0] sck_q, ss_q, cnt_q, cnt_d;
   logic [1:0] di_q;
   logic [6:0] rx_q, rx_d;
   logic [7:0] tx_q, tx_d, pre_q, pre_d, idx_q, idx_d, rx_byte;
   logic [24:0] addr_q, addr_d;
   logic up_q, up_d, rd_d, load, sck_rise, sck_fall;
   logic [RD_LATENCY:0] rdp_q;
`ifdef UPLOAD_CHECKSUM_EN
   logic [7:0] sum_q, sum_d, cur_q, cur_d;
`endif
   assign sck_rise     = sck_q[1] & ~sck_q[2];
   assign sck_fall     = ~sck_q[1] & sck_q[2];
   assign rx_byte      = {rx_q, di_q[1]};
   assign SPI_DO       = tx_q[7];
   assign SPI_DO_EN    = ~ss_q[1];
   assign ioctl_upload = up_q;
   assign ioctl_index  = idx_q;
   assign ioctl_rd     = rdp_q[0];
   assign ioctl_addr   = addr_q;
   // two-flop synchronisers; the third SCK/SS stage gives the previous value for edge detection
   always_ff @(posedge clock_12 or posedge reset)
      if (reset) begin
         sck_q <= '0;
         ss_q  <= '1;
         di_q  <= '0;
      end else begin
         sck_q <= {sck_q[1:0], SPI_SCK};
         ss_q  <= {ss_q[1:0], SPI_SS2};
         di_q  <= {di_q[0], SPI_DI};
      end
   // framing, command decode, byte-boundary loads and prefetch capture
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      pre_d   = rdp_q[RD_LATENCY] ? ioctl_din : pre_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      up_d    = up_q;
      rd_d    = 1'b0;
      load    = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      sum_d   = sum_q;
      cur_d   = cur_q;
`endif
      if (ss_q[1]) begin
         state_d = IDLE;
         cnt_d   = '0;
         tx_d    = '0;
      end else if (ss_q[2]) begin
         state_d = CMD;
         cnt_d   = '0;
         tx_d    = '0;
      end else begin
         if (sck_rise) begin
            rx_d  = rx_byte[6:0];
            cnt_d = cnt_q + 3'd1;
         end
         // the falling edge right after a byte boundary keeps the freshly loaded MSB on the wire
         if (sck_fall && cnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b0};
         if (sck_rise && cnt_q == 3'd7)
            case (state_q)
               CMD: begin
                  load    = rx_byte == CMD_RX_DAT && up_q;
                  state_d = rx_byte == CMD_INDEX ? ARG_INDEX : rx_byte == CMD_RX_CTRL ? ARG_CTRL : load ? DATA : IDLE;
`ifdef UPLOAD_CHECKSUM_EN
                  if (rx_byte == 8'h59) tx_d = sum_q;
`endif
               end
               ARG_INDEX: begin
                  idx_d   = rx_byte;
                  state_d = IDLE;
               end
               ARG_CTRL: begin
                  up_d    = |rx_byte;
                  state_d = IDLE;
                  if (|rx_byte) begin
                     addr_d = '0;
                     rd_d   = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
                     sum_d  = '0;
`endif
                  end
               end
               DATA: begin
                  load = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
                  sum_d = sum_q + cur_q;
`endif
               end
               default: ;
            endcase
      end
      if (load) begin
         tx_d   = pre_q;
         addr_d = addr_q + 25'd1;
         rd_d   = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
         cur_d  = pre_q;
`endif
      end
   end
   // state registers; rdp_q delays the read strobe to the cycle ioctl_din is valid
   always_ff @(posedge clock_12 or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rx_q    <= '0;
         tx_q    <= '0;
         pre_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         up_q    <= 1'b0;
         rdp_q   <= '0;
`ifdef UPLOAD_CHECKSUM_EN
         sum_q   <= '0;
         cur_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         pre_q   <= pre_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         up_q    <= up_d;
         rdp_q   <= {rdp_q[RD_LATENCY-1:0], rd_d};
`ifdef UPLOAD_CHECKSUM_EN
         sum_q   <= sum_d;
         cur_q   <= cur_d;
`endif
      end
endmodule

// File: tb/tb_ioctl_upload_io.sv
// tb_ioctl_upload_io: directed SPI transactions checked against a byte-level upload model
module tb_ioctl_upload_io;
   localparam int LAT = 2;
`ifdef UPLOAD_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss2 = 1'b1, di = 1'b0;
   logic spi_do, spi_do_en, up, rd;
   logic [7:0] idx, din;
   logic [24:0] addr;
   ioctl_upload_io #(.RD_LATENCY(LAT)) dut (
      .clock_12(clk), .reset(rst), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
      .SPI_DO(spi_do), .SPI_DO_EN(spi_do_en), .ioctl_upload(up), .ioctl_index(idx),
      .ioctl_rd(rd), .ioctl_addr(addr), .ioctl_din(din)
   );
   always #5 clk = ~clk;

   function automatic logic [7:0] mem(input logic [24:0] a);
      return 8'hA0 + a[7:0];
   endfunction

   // core memory: data valid only in the single cycle LAT cycles after the strobe
   logic [3:0] rdh = '0;
   logic [24:0] adh [4];
   always @(posedge clk) begin
      rdh <= {rdh[2:0], rd};
      adh[0] <= addr;
      adh[1] <= adh[0];
      adh[2] <= adh[1];
      adh[3] <= adh[2];
   end
   assign din = rdh[LAT-1] ? mem(adh[LAT-1]) : 8'hEE;

   int rd_cnt = 0;
   always @(posedge clk) if (rd) rd_cnt <= rd_cnt + 1;

   int n_cmp = 0, n_fail = 0;
   bit settled = 1'b0;
   logic m_up = 1'b0;
   logic [7:0] m_idx = '0, m_sum = '0;
   logic [24:0] m_addr = '0;
   logic [7:0] tb_tx [6];
   logic [7:0] tb_rx [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // outputs must match the model whenever no transaction is in flight
   always @(negedge clk)
      if (settled && !rst) begin
         chk("upload", {31'd0, up}, {31'd0, m_up});
         chk("index", {24'd0, idx}, {24'd0, m_idx});
         chk("addr", {7'd0, addr}, {7'd0, m_addr});
         chk("rd_idle", {31'd0, rd}, 32'd0);
         chk("do_en_idle", {31'd0, spi_do_en}, 32'd0);
         chk("do_idle", {31'd0, spi_do}, 32'd0);
      end

   task automatic xfer(input int nbits);
      settled = 1'b0;
      ss2 = 1'b0;
      tick(6);
      for (int i = 0; i < nbits; i++) begin
         di = tb_tx[i/8][7-i%8];
         tick(6);
         tb_rx[i/8][7-i%8] = spi_do;
         if (!rst) chk("do_en_active", {31'd0, spi_do_en}, 32'd1);
         sck = 1'b1;
         tick(6);
         sck = 1'b0;
      end
      tick(6);
      ss2 = 1'b1;
      tick(8);
   endtask

   task automatic run(input int nbits);
      int nb = nbits / 8;
      int r0 = rd_cnt;
      int nrd = 0;
      logic [7:0] cmd = tb_tx[0];
      logic [7:0] exp;
      xfer(nbits);
      if (nb >= 1) chk("miso_cmd", {24'd0, tb_rx[0]}, 32'd0);
      for (int k = 1; k < nb; k++) begin
         exp = (cmd == 8'h58 && m_up) ? mem(m_addr + 25'(k-1)) : (CK && cmd == 8'h59 && k == 1) ? m_sum : 8'h00;
         chk($sformatf("miso[%0d]", k), {24'd0, tb_rx[k]}, {24'd0, exp});
      end
      if (nb >= 2 && cmd == 8'h55) m_idx = tb_tx[1];
      if (nb >= 2 && cmd == 8'h57) begin
         m_up = tb_tx[1] != 8'h00;
         if (m_up) begin
            m_addr = '0;
            m_sum = '0;
            nrd = 1;
         end
      end
      if (nb >= 1 && cmd == 8'h58 && m_up) begin
         for (int j = 0; j < nb - 1; j++) m_sum += mem(m_addr + 25'(j));
         m_addr += 25'(nb);
         nrd = nb;
      end
      chk("rd_pulses", rd_cnt - r0, nrd);
      settled = 1'b1;
   endtask

   initial begin
      int r0;
      tick(4);
      chk("rst_do", {31'd0, spi_do}, 32'd0);
      chk("rst_do_en", {31'd0, spi_do_en}, 32'd0);
      chk("rst_upload", {31'd0, up}, 32'd0);
      chk("rst_index", {24'd0, idx}, 32'd0);
      chk("rst_rd", {31'd0, rd}, 32'd0);
      chk("rst_addr", {7'd0, addr}, 32'd0);
      rst = 1'b0;
      tick(4);
      settled = 1'b1;
      tb_tx[0] = 8'h55; tb_tx[1] = 8'h02;
      run(16);
      chk("index_lit", {24'd0, idx}, 32'h02);
      chk("upload_after_index", {31'd0, up}, 32'd0);
      tb_tx[0] = 8'h33; tb_tx[1] = 8'h00;
      run(16);
      tb_tx[0] = 8'h57; tb_tx[1] = 8'hFF;
      run(16);
      chk("upload_on", {31'd0, up}, 32'd1);
      tb_tx[0] = 8'h58; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00; tb_tx[3] = 8'h00; tb_tx[4] = 8'h00;
      r0 = rd_cnt;
      run(40);
      chk("stream0_lit", {24'd0, tb_rx[1]}, 32'hA0);
      chk("stream1_lit", {24'd0, tb_rx[2]}, 32'hA1);
      chk("stream2_lit", {24'd0, tb_rx[3]}, 32'hA2);
      chk("stream3_lit", {24'd0, tb_rx[4]}, 32'hA3);
      chk("addr5_lit", {7'd0, addr}, 32'd5);
      chk("rd5_lit", rd_cnt - r0, 32'd5);
      tb_tx[0] = 8'h59; tb_tx[1] = 8'h00;
      run(16);
      chk("sum_lit", {24'd0, tb_rx[1]}, CK ? 32'h86 : 32'h00);
      tb_tx[0] = 8'h57; tb_tx[1] = 8'hFF;
      run(16);
      tb_tx[0] = 8'h58; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00;
      run(19);
      chk("abort_addr_lit", {7'd0, addr}, 32'd2);
      run(16);
      chk("resume_lit", {24'd0, tb_rx[1]}, 32'hA2);
      tb_tx[0] = 8'h57; tb_tx[1] = 8'h00;
      run(16);
      tb_tx[0] = 8'h58; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00;
      r0 = rd_cnt;
      run(24);
      chk("off_byte1_lit", {24'd0, tb_rx[1]}, 32'd0);
      chk("off_byte2_lit", {24'd0, tb_rx[2]}, 32'd0);
      chk("off_rd_lit", rd_cnt - r0, 32'd0);
      tb_tx[0] = 8'h57; tb_tx[1] = 8'hFF;
      run(16);
      tb_tx[0] = 8'h58; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00; tb_tx[3] = 8'h00; tb_tx[4] = 8'h00;
      fork
         xfer(40);
         begin
            tick(6 + 3 * 96 + 40);
            rst = 1'b1;
            #1;
            chk("mid_rst_upload", {31'd0, up}, 32'd0);
            chk("mid_rst_addr", {7'd0, addr}, 32'd0);
            chk("mid_rst_rd", {31'd0, rd}, 32'd0);
            chk("mid_rst_do", {31'd0, spi_do}, 32'd0);
            chk("mid_rst_do_en", {31'd0, spi_do_en}, 32'd0);
            chk("mid_rst_index", {24'd0, idx}, 32'd0);
         end
      join
      m_up = 1'b0; m_idx = '0; m_addr = '0; m_sum = '0;
      tick(2);
      rst = 1'b0;
      tick(4);
      settled = 1'b1;
      tick(20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
